// File: rtl/sdspi_cmd_seq_if.sv
// Signal bundle between the SD command sequencer, its requester (cmd_*) and the
// byte-level SPI master (spi_*). The sequencer takes the master modport.
interface sdspi_cmd_seq_if;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [2:0]  resp_bytes;
  logic        cmd_busy;
  logic        cmd_done;
  logic [7:0]  r1;
  logic [31:0] resp_data;
  logic        timeout_err;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out;
  logic        spi_w_data;
  logic        spi_w_conf;
  logic        spi_ss_in;
  logic        spi_busy;

  modport master (
    input  cmd_start, cmd_index, cmd_arg, cmd_crc, resp_bytes,
    output cmd_busy, cmd_done, r1, resp_data, timeout_err,
    output spi_data_in, spi_w_data, spi_w_conf, spi_ss_in,
    input  spi_data_out, spi_busy
  );

  modport slave (
    output cmd_start, cmd_index, cmd_arg, cmd_crc, resp_bytes,
    input  cmd_busy, cmd_done, r1, resp_data, timeout_err,
    input  spi_data_in, spi_w_data, spi_w_conf, spi_ss_in,
    output spi_data_out, spi_busy
  );
endinterface

// File: rtl/sdspi_cmd_seq.sv
// Issues one SD SPI-mode command frame through a byte SPI master, polls for R1
// and collects up to four trailing response bytes.
module sdspi_cmd_seq #(
  parameter logic [7:0] CLK_DIV    = 8'd6,
  parameter int         R1_TIMEOUT = 8
) (
  input logic            clk,
  input logic            rst,
  sdspi_cmd_seq_if.master bus
);
  localparam logic [7:0] TIMEOUT_W = 8'(R1_TIMEOUT);

  typedef enum logic [3:0] {
    S_CONF, S_IDLE, S_LOAD, S_SEND, S_GUARD, S_WAIT, S_POLL, S_RESP, S_DONE
  } state_t;
  typedef enum logic [1:0] {PH_FRAME, PH_POLL, PH_RESP} phase_t;

  state_t      r_state;
  phase_t      r_phase;
  logic [5:0]  r_idx;
  logic [31:0] r_arg;
  logic [6:0]  r_crc;
  logic [2:0]  r_resp_n;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_poll_cnt;
  logic [2:0]  r_resp_cnt;
  logic        r_guard_cnt;
  logic        r_ss;
  logic        r_w_data;
  logic        r_w_conf;
  logic [7:0]  r_data_in;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_r1;
  logic [31:0] r_resp_data;
  logic        r_timeout;
  logic [7:0]  w_frame_byte;
  logic [2:0]  w_resp_n;

  assign w_resp_n = (bus.resp_bytes > 3'd4) ? 3'd4 : bus.resp_bytes;

  always_comb begin
    w_frame_byte = 8'hFF;
    case (r_byte_cnt)
      3'd0:    w_frame_byte = {2'b01, r_idx};
      3'd1:    w_frame_byte = r_arg[31:24];
      3'd2:    w_frame_byte = r_arg[23:16];
      3'd3:    w_frame_byte = r_arg[15:8];
      3'd4:    w_frame_byte = r_arg[7:0];
      3'd5:    w_frame_byte = {r_crc, 1'b1};
      default: w_frame_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CONF;
      r_phase     <= PH_FRAME;
      r_idx       <= '0;
      r_arg       <= '0;
      r_crc       <= '0;
      r_resp_n    <= '0;
      r_byte_cnt  <= '0;
      r_poll_cnt  <= '0;
      r_resp_cnt  <= '0;
      r_guard_cnt <= 1'b0;
      r_ss        <= 1'b1;
      r_w_data    <= 1'b0;
      r_w_conf    <= 1'b0;
      r_data_in   <= 8'hFF;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_r1        <= 8'hFF;
      r_resp_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_w_data <= 1'b0;
      r_w_conf <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_CONF: begin
          r_w_conf  <= 1'b1;
          r_data_in <= CLK_DIV;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.cmd_start) begin
            r_idx       <= bus.cmd_index;
            r_arg       <= bus.cmd_arg;
            r_crc       <= bus.cmd_crc;
            r_resp_n    <= w_resp_n;
            r_timeout   <= 1'b0;
            r_resp_data <= '0;
            r_byte_cnt  <= '0;
            r_phase     <= PH_FRAME;
            r_ss        <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        // w_data is raised here so it is high exactly while in SEND.
        S_LOAD: begin
          r_data_in <= w_frame_byte;
          r_w_data  <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          r_guard_cnt <= 1'b0;
          r_state     <= S_GUARD;
        end
        S_GUARD: begin
          if (r_guard_cnt) r_state <= S_WAIT;
          else             r_guard_cnt <= 1'b1;
        end
        S_WAIT: begin
          if (!bus.spi_busy) begin
            case (r_phase)
              PH_FRAME: begin
                if (r_byte_cnt == 3'd5) begin
                  r_poll_cnt <= '0;
                  r_phase    <= PH_POLL;
                  r_state    <= S_POLL;
                end else begin
                  r_byte_cnt <= r_byte_cnt + 3'd1;
                  r_state    <= S_LOAD;
                end
              end
              PH_POLL: begin
                if (!bus.spi_data_out[7]) begin
                  r_r1 <= bus.spi_data_out;
                  if (r_resp_n != 3'd0) begin
                    r_resp_cnt <= '0;
                    r_phase    <= PH_RESP;
                    r_state    <= S_RESP;
                  end else begin
                    r_state <= S_DONE;
                  end
                end else if (r_poll_cnt + 8'd1 == TIMEOUT_W) begin
                  r_r1      <= 8'hFF;
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
                end else begin
                  r_poll_cnt <= r_poll_cnt + 8'd1;
                  r_state    <= S_POLL;
                end
              end
              default: begin
                r_resp_data <= {r_resp_data[23:0], bus.spi_data_out};
                r_resp_cnt  <= r_resp_cnt + 3'd1;
                if (r_resp_cnt + 3'd1 == r_resp_n) r_state <= S_DONE;
                else                               r_state <= S_RESP;
              end
            endcase
          end
        end
        S_POLL, S_RESP: begin
          r_data_in <= 8'hFF;
          r_w_data  <= 1'b1;
          r_state   <= S_SEND;
        end
        S_DONE: begin
          r_ss    <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_CONF;
      endcase
    end
  end

  assign bus.cmd_busy    = r_busy;
  assign bus.cmd_done    = r_done;
  assign bus.r1          = r_r1;
  assign bus.resp_data   = r_resp_data;
  assign bus.timeout_err = r_timeout;
  assign bus.spi_data_in = r_data_in;
  assign bus.spi_w_data  = r_w_data;
  assign bus.spi_w_conf  = r_w_conf;
  assign bus.spi_ss_in   = r_ss;
endmodule

// File: tb/tb_sdspi_cmd_seq.sv
// Directed bench for sdspi_cmd_seq: a behavioural SPI slave feeds MISO bytes and
// checks MOSI against a queue; a done monitor checks results against a queue.
module tb_sdspi_cmd_seq;
  typedef struct packed {
    logic [7:0]  r1;
    logic [31:0] resp;
    logic        to;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdspi_cmd_seq_if bus();

  sdspi_cmd_seq #(.CLK_DIV(8'd6), .R1_TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int rx_cnt   = 0;
  logic [7:0] exp_mosi_q[$];
  logic [7:0] miso_q[$];
  res_t       exp_res_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SPI slave: first 6 bytes of each select window return FF, later ones come from miso_q.
  initial begin : slave
    int idx;
    logic [7:0] b;
    idx = 0;
    bus.spi_busy     = 1'b0;
    bus.spi_data_out = 8'hFF;
    forever begin
      @(negedge clk);
      if (bus.spi_ss_in) idx = 0;
      if (bus.spi_w_data) begin
        b = bus.spi_data_in;
        rx_cnt++;
        check("ss_low_at_send", 32'(bus.spi_ss_in), 32'd0);
        if (exp_mosi_q.size() == 0) check("mosi_extra_byte", 32'(b), 32'h100);
        else                        check("mosi_byte", 32'(b), 32'(exp_mosi_q.pop_front()));
        bus.spi_busy = 1'b1;
        repeat (4) @(negedge clk);
        if (idx >= 6 && miso_q.size() > 0) bus.spi_data_out = miso_q.pop_front();
        else                                bus.spi_data_out = 8'hFF;
        idx++;
        bus.spi_busy = 1'b0;
      end
    end
  end

  initial begin : done_mon
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.cmd_done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", 32'(bus.cmd_done), 32'd0);
        end else begin
          r = exp_res_q.pop_front();
          check("r1", 32'(bus.r1), 32'(r.r1));
          check("resp_data", bus.resp_data, r.resp);
          check("timeout_err", 32'(bus.timeout_err), 32'(r.to));
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input logic [2:0] rb);
    @(negedge clk);
    bus.cmd_index  = idx;
    bus.cmd_arg    = arg;
    bus.cmd_crc    = crc;
    bus.resp_bytes = rb;
    bus.cmd_start  = 1'b1;
    @(negedge clk);
    bus.cmd_start  = 1'b0;
    bus.cmd_index  = ~idx;
    bus.cmd_arg    = ~arg;
    bus.cmd_crc    = ~crc;
    bus.resp_bytes = ~rb;
    check("busy_after_start", 32'(bus.cmd_busy), 32'd1);
  endtask

  task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    exp_mosi_q.push_back({2'b01, idx});
    exp_mosi_q.push_back(arg[31:24]);
    exp_mosi_q.push_back(arg[23:16]);
    exp_mosi_q.push_back(arg[15:8]);
    exp_mosi_q.push_back(arg[7:0]);
    exp_mosi_q.push_back({crc, 1'b1});
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input logic [2:0] rb, input int n_poll, input logic [7:0] e_r1,
                         input logic [31:0] e_resp, input logic e_to, input bit poke);
    int d0;
    int nr;
    res_t r;
    push_frame(idx, arg, crc);
    nr = e_to ? 0 : ((rb > 3'd4) ? 4 : int'(rb));
    for (int k = 0; k < n_poll + nr; k++) exp_mosi_q.push_back(8'hFF);
    r.r1 = e_r1;
    r.resp = e_resp;
    r.to = e_to;
    exp_res_q.push_back(r);
    d0 = done_cnt;
    start_pulse(idx, arg, crc, rb);
    if (poke) begin
      repeat (20) @(negedge clk);
      bus.cmd_start = 1'b1;
      bus.cmd_index = 6'd17;
      @(negedge clk);
      bus.cmd_start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.cmd_done), 32'd0);
    check("ss_after_done", 32'(bus.spi_ss_in), 32'd1);
    check("idle_not_busy", 32'(bus.cmd_busy), 32'd0);
    check("mosi_left", 32'(exp_mosi_q.size()), 32'd0);
    check("miso_left", 32'(miso_q.size()), 32'd0);
    if (poke) begin
      repeat (200) @(negedge clk);
      check("single_done", 32'(done_cnt - d0), 32'd1);
      check("single_frame", 32'(exp_mosi_q.size()), 32'd0);
    end
    $display("cmd%0d arg=%h r1=%h resp=%h timeout=%0d", idx, arg, bus.r1, bus.resp_data, bus.timeout_err);
  endtask

  initial begin : main
    int d0;
    int r0;
    bus.cmd_start  = 1'b0;
    bus.cmd_index  = '0;
    bus.cmd_arg    = '0;
    bus.cmd_crc    = '0;
    bus.resp_bytes = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(bus.spi_ss_in), 32'd1);
    check("rst_w_data", 32'(bus.spi_w_data), 32'd0);
    check("rst_w_conf", 32'(bus.spi_w_conf), 32'd0);
    check("rst_data_in", 32'(bus.spi_data_in), 32'hFF);
    check("rst_busy", 32'(bus.cmd_busy), 32'd1);
    check("rst_done", 32'(bus.cmd_done), 32'd0);
    check("rst_r1", 32'(bus.r1), 32'hFF);
    check("rst_resp", bus.resp_data, 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("conf_pulse", 32'(bus.spi_w_conf), 32'd1);
    check("conf_div", 32'(bus.spi_data_in), 32'h06);
    check("conf_busy_low", 32'(bus.cmd_busy), 32'd0);
    @(negedge clk);
    check("conf_single", 32'(bus.spi_w_conf), 32'd0);
    repeat (3) @(negedge clk);

    // CMD0: FF then R1=01
    miso_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 2, 8'h01, 32'h0, 1'b0, 1'b0);
    // CMD8 with R7 trailing bytes
    miso_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_cmd(6'd8, 32'h1AA, 7'h43, 3'd4, 1, 8'h01, 32'h000001AA, 1'b0, 1'b0);
    // No R1 at all: eight polls then timeout, no trailing reads
    run_cmd(6'd55, 32'h0, 7'h32, 3'd2, 8, 8'hFF, 32'h0, 1'b1, 1'b0);
    // resp_bytes=7 behaves as 4
    miso_q = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(6'd58, 32'hDEADBEEF, 7'h2B, 3'd7, 1, 8'h05, 32'h11223344, 1'b0, 1'b0);
    // R1 on the last allowed poll byte
    miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hAB, 8'hCD};
    run_cmd(6'd13, 32'h12345678, 7'h11, 3'd2, 8, 8'h00, 32'h0000ABCD, 1'b0, 1'b0);
    // Second start during the frame is ignored
    miso_q = '{8'h01};
    run_cmd(6'd16, 32'h200, 7'h0A, 3'd0, 1, 8'h01, 32'h0, 1'b0, 1'b1);

    // Reset while the third frame byte is on the wire
    exp_mosi_q.push_back(8'h51);
    exp_mosi_q.push_back(8'h00);
    exp_mosi_q.push_back(8'h00);
    d0 = done_cnt;
    r0 = rx_cnt;
    start_pulse(6'd17, 32'h00001234, 7'h55, 3'd0);
    for (int k = 0; k < 500 && rx_cnt < r0 + 3; k++) @(posedge clk);
    check("reached_byte3", 32'(rx_cnt - r0), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss", 32'(bus.spi_ss_in), 32'd1);
    check("abort_busy", 32'(bus.cmd_busy), 32'd1);
    check("abort_w_data", 32'(bus.spi_w_data), 32'd0);
    check("abort_r1", 32'(bus.r1), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    check("reconf_pulse", 32'(bus.spi_w_conf), 32'd1);
    check("reconf_div", 32'(bus.spi_data_in), 32'h06);
    @(negedge clk);
    check("reconf_single", 32'(bus.spi_w_conf), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_mosi_left", 32'(exp_mosi_q.size()), 32'd0);
    $display("cmd17 aborted by reset after %0d bytes", rx_cnt - r0);

    // Clean command after the abort
    miso_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 2, 8'h01, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
